// File: rtl/verinject_ff_injector_seq.sv
// Sequential fault injector on one register vector: timed or persistent flip / stuck-at faults,
// adjacent multi-bit upsets, retrigger and clear control, plus a saturating injection counter.
module verinject_ff_injector_seq #(
    parameter int          LEFT      = 0,
    parameter int          RIGHT     = 0,
    parameter logic [31:0] P_START   = 32'd0,
    parameter int          MBU_WIDTH = 1,
    parameter int          HOLD_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [LEFT:RIGHT] unmodified,
    output logic [LEFT:RIGHT] modified,
    input  logic [31:0]       verinject__injector_state,
    input  logic              inject_strobe,
    input  logic [1:0]        inject_mode,
    input  logic [HOLD_W-1:0] inject_hold,
    input  logic              fault_clear,
    output logic              fault_active,
    output logic [15:0]       inject_count
);

    localparam int N     = (LEFT >= RIGHT) ? (LEFT - RIGHT + 1) : (RIGHT - LEFT + 1);
    localparam int LO    = (LEFT <= RIGHT) ? LEFT : RIGHT;
    localparam int MBU   = (MBU_WIDTH > N) ? N : ((MBU_WIDTH < 1) ? 1 : MBU_WIDTH);
    localparam int OFF_W = (N > 1) ? $clog2(N) : 1;

    // 33-bit bounds so the top of the window never wraps past 2^32-1
    localparam logic [32:0] LO_BOUND = {1'b0, P_START};
    localparam logic [32:0] HI_BOUND = {1'b0, P_START} + 33'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Adjacent-bit mask starting at off, truncated at the top of the vector
    function automatic logic [N-1:0] mbu_mask(input logic [OFF_W-1:0] off);
        logic [N-1:0] m;
        m = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            m[i] = (i >= int'(off)) && (i < int'(off) + MBU);
        end
        return m;
    endfunction

    state_t            state_r;
    logic              fault_active_r;
    logic [15:0]       count_r;
    logic [OFF_W-1:0]  off_r;
    logic [1:0]        mode_r;
    logic [HOLD_W-1:0] remain_r;
    logic              perm_r;

    logic [32:0]       state_ext_s;
    logic              in_range_s;
    logic              accept_s;
    logic [OFF_W-1:0]  off_s;
    logic [N-1:0]      norm_in_s;
    logic [N-1:0]      norm_out_s;
    logic [N-1:0]      mask_s;

    assign state_ext_s = {1'b0, verinject__injector_state};
    assign in_range_s  = (state_ext_s >= LO_BOUND) && (state_ext_s <= HI_BOUND);
    assign accept_s    = inject_strobe && in_range_s && !fault_clear;
    assign off_s       = OFF_W'(state_ext_s - LO_BOUND);
    assign mask_s      = mbu_mask(off_r);

    // Offset o always addresses index LO+o, whatever the declaration order
    for (genvar g = 0; g < N; g++) begin : g_map
        assign norm_in_s[g]     = unmodified[LO + g];
        assign modified[LO + g] = norm_out_s[g];
    end

    // Apply the registered mask to the live data without adding latency
    always_comb begin
        norm_out_s = norm_in_s;
        if (state_r == ST_ACTIVE) begin
            case (mode_r)
                2'd1:    norm_out_s = norm_in_s & ~mask_s;
                2'd2:    norm_out_s = norm_in_s | mask_s;
                default: norm_out_s = norm_in_s ^ mask_s;
            endcase
        end else begin
            norm_out_s = norm_in_s;
        end
    end

    // Fault FSM: accept/retrigger, timed expiry, clear, and the injection counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            fault_active_r <= 1'b0;
            count_r        <= 16'd0;
            off_r          <= {OFF_W{1'b0}};
            mode_r         <= 2'd0;
            remain_r       <= {HOLD_W{1'b0}};
            perm_r         <= 1'b0;
        end else if (accept_s) begin
            state_r        <= ST_ACTIVE;
            fault_active_r <= 1'b1;
            off_r          <= off_s;
            mode_r         <= inject_mode;
            remain_r       <= inject_hold;
            perm_r         <= (inject_hold == {HOLD_W{1'b0}});
            if (count_r != 16'hFFFF) begin
                count_r <= count_r + 16'd1;
            end
        end else begin
            case (state_r)
                ST_ACTIVE: begin
                    // remain_r==1 marks the last masked cycle of a timed fault
                    if (fault_clear || (!perm_r && (remain_r == HOLD_W'(1'b1)))) begin
                        state_r        <= ST_IDLE;
                        fault_active_r <= 1'b0;
                    end else if (!perm_r) begin
                        remain_r <= remain_r - HOLD_W'(1'b1);
                    end
                end
                ST_IDLE: begin
                    state_r        <= ST_IDLE;
                    fault_active_r <= 1'b0;
                end
                default: begin
                    state_r        <= ST_IDLE;
                    fault_active_r <= 1'b0;
                end
            endcase
        end
    end

    assign fault_active = fault_active_r;
    assign inject_count = count_r;

endmodule
